// File: rtl/rf_dump_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_dump_pkg
//  Purpose  : Shared constants for the register-file dump scanner
//             (state encoding, default widths, register count).
//  Revision : 1.0 - initial release
// ============================================================================
package rf_dump_pkg;

  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int NUM_REGS = 32;

  // Scanner states, legacy-compatible 2-bit encoding
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/rf_dump_shadow.sv
`default_nettype none
// ============================================================================
//  Module   : rf_dump_shadow
//  Purpose  : Holds the last emitted value of every register plus a seen bit,
//             so the scanner can suppress beats whose value is unchanged.
//             Only the seen bits are reset; a stale shadow value is harmless
//             because it is never trusted without its seen bit.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_dump_shadow
  import rf_dump_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_idx,
  input  logic [DW-1:0] cmp_data,
  output logic          hit,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    shadow_q [DEPTH];
  logic [DW-1:0]    shadow_d [DEPTH];
  logic [DEPTH-1:0] seen_q;
  logic [DEPTH-1:0] seen_d;

  // Next-state: record value and mark seen on each accepted beat
  always_comb begin
    shadow_d = shadow_q;
    seen_d   = seen_q;
    if (wr_en) begin
      shadow_d[wr_idx] = wr_data;
      seen_d[wr_idx]   = 1'b1;
    end
  end

  // Shadow value storage (no reset needed, qualified by seen bits)
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  // Seen bits, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seen_q <= '0;
    else        seen_q <= seen_d;
  end

  assign hit = seen_q[rd_idx] && (shadow_q[rd_idx] == cmp_data);

endmodule
`default_nettype wire

// File: rtl/rf_dump_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : rf_dump_scanner
//  Purpose  : Walks a (possibly wrapping) register range through the register
//             file debug port and emits each value as an index/value beat on
//             a valid/ready stream.
//  Options  : RF_DUMP_DELTA_EN - suppress beats whose value matches the last
//             value emitted for that register.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_dump_scanner
  import rf_dump_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] reg_sel,
  input  logic [DW-1:0] reg_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] last_q, last_d;
  logic [AW-1:0] reg_sel_q, reg_sel_d;
  logic          out_valid_q, out_valid_d;
  logic [AW-1:0] out_idx_q, out_idx_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic [AW-1:0] ptr_next;
  logic          at_last;
  logic          handshake;
  logic          skip;

  assign ptr_next  = ptr_q + AW'(1);   // natural wrap gives the modulo range
  assign at_last   = (ptr_q == last_q);
  assign handshake = out_valid_q & out_ready;

`ifdef RF_DUMP_DELTA_EN
  logic shadow_hit;

  rf_dump_shadow #(
    .AW (AW),
    .DW (DW)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (ptr_q),
    .cmp_data (reg_data),
    .hit      (shadow_hit),
    .wr_en    (handshake),
    .wr_idx   (out_idx_q),
    .wr_data  (out_data_q)
  );

  // Only meaningful in FETCH, where reg_sel equals ptr
  assign skip = shadow_hit;
`else
  assign skip = 1'b0;
`endif

  // Scan sequencer: next-state and output-register computation
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    reg_sel_d   = reg_sel_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    case (state_q)
      ST_IDLE: begin
        reg_sel_d = '0;
        if (start) begin
          last_d    = last;
          ptr_d     = first;
          reg_sel_d = first;
          state_d   = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (skip) begin
          // Unchanged value: advance without emitting a beat
          if (at_last) begin
            reg_sel_d = '0;
            state_d   = ST_DONE;
          end else begin
            ptr_d     = ptr_next;
            reg_sel_d = ptr_next;
          end
        end else begin
          out_data_d  = reg_data;
          out_idx_d   = ptr_q;
          out_last_d  = at_last;
          out_valid_d = 1'b1;
          state_d     = ST_SEND;
        end
      end

      ST_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (at_last) begin
            reg_sel_d = '0;
            state_d   = ST_DONE;
          end else begin
            ptr_d     = ptr_next;
            reg_sel_d = ptr_next;
            state_d   = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        reg_sel_d = '0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any scan in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      reg_sel_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      reg_sel_q   <= reg_sel_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = (state_q == ST_FETCH) || (state_q == ST_SEND);
  assign done      = (state_q == ST_DONE);
  assign reg_sel   = reg_sel_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_dump_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_dump_scanner
//  Purpose  : Self-checking bench for rf_dump_scanner with a behavioural
//             register-file / stream-sink reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_dump_scanner;

  localparam int AW = 5;
  localparam int DW = 32;
`ifdef RF_DUMP_DELTA_EN
  localparam bit DELTA = 1'b1;
`else
  localparam bit DELTA = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] first;
  logic [AW-1:0] last;
  logic          busy;
  logic          done;
  logic [AW-1:0] reg_sel;
  logic [DW-1:0] reg_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_idx;
  logic [DW-1:0] out_data;
  logic          out_last;

  // Behavioural register file and reference shadow state
  logic [DW-1:0] rf     [32];
  logic [DW-1:0] shadow [32];
  bit            seen   [32];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign reg_data = rf[reg_sel];

  rf_dump_scanner #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .first     (first),
    .last      (last),
    .busy      (busy),
    .done      (done),
    .reg_sel   (reg_sel),
    .reg_data  (reg_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
  endtask

  // One complete scan. ready_mode: 0 = always ready, 1 = random,
  // 2 = hold ready low for 5 cycles on beat number stall_beat.
  task automatic do_scan(input logic [AW-1:0] f, input logic [AW-1:0] l,
                         input int ready_mode, input int stall_beat,
                         input bit poke, input string name);
    int            exp_idx[$];
    logic [DW-1:0] exp_data[$];
    bit            exp_last[$];
    int n, emit, skip, skip_first, first_valid_t;
    int t, beat, stalls, stall_cnt;
    bit got_done, holding, seen_valid;
    logic [AW-1:0] h_idx;
    logic [DW-1:0] h_data;
    logic          h_last;

    // Expected beats from the range rules
    n = ((int'(l) - int'(f) + 32) % 32) + 1;
    emit = 0; skip = 0; skip_first = 0;
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = (int'(f) + i) % 32;
      if (DELTA && seen[idx] && shadow[idx] == rf[idx]) begin
        skip++;
        if (emit == 0) skip_first++;
      end else begin
        exp_idx.push_back(idx);
        exp_data.push_back(rf[idx]);
        exp_last.push_back(idx == int'(l));
        emit++;
      end
    end
    first_valid_t = 2 + skip_first;

    start = 1'b1; first = f; last = l;
    out_ready = (ready_mode != 1) ? 1'b1 : 1'b0;
    tick();
    start = 1'b0;

    t = 1; beat = 0; stalls = 0; stall_cnt = 0;
    got_done = 0; holding = 0; seen_valid = 0;
    h_idx = '0; h_data = '0; h_last = 1'b0;
    while (t < 400 && !got_done) begin
      start = 1'b0;
      if (done === 1'b1) begin
        got_done = 1;
        checks++;
        if (t != 1 + 2 * emit + skip + stalls) begin
          errors++;
          $display("FAIL %s done_time: got t=%0d want t=%0d", name, t, 1 + 2 * emit + skip + stalls);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || reg_sel !== '0) begin
          errors++;
          $display("FAIL %s done_outputs: busy=%b valid=%b sel=%0d want 0/0/0", name, busy, out_valid, reg_sel);
        end
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy: got %b at t=%0d want 1", name, busy, t);
        end
        if (t == 1) begin
          checks++;
          if (reg_sel !== f) begin
            errors++;
            $display("FAIL %s reg_sel_first: got %0d want %0d", name, reg_sel, f);
          end
        end
        if (out_valid === 1'b1) begin
          if (!seen_valid) begin
            seen_valid = 1;
            checks++;
            if (t != first_valid_t) begin
              errors++;
              $display("FAIL %s first_valid_time: got t=%0d want t=%0d", name, t, first_valid_t);
            end
          end
          if (holding) begin
            checks++;
            if (out_idx !== h_idx || out_data !== h_data || out_last !== h_last) begin
              errors++;
              $display("FAIL %s stable: got (%0d,%h,%b) want (%0d,%h,%b)", name,
                       out_idx, out_data, out_last, h_idx, h_data, h_last);
            end
          end
          checks++;
          if (beat >= exp_idx.size()) begin
            errors++;
            $display("FAIL %s extra_beat: got idx %0d beyond %0d expected beats", name, out_idx, exp_idx.size());
          end else if (out_idx !== AW'(exp_idx[beat]) || out_data !== exp_data[beat] ||
                       out_last !== exp_last[beat]) begin
            errors++;
            $display("FAIL %s beat%0d: got (%0d,%h,%b) want (%0d,%h,%b)", name, beat,
                     out_idx, out_data, out_last, exp_idx[beat], exp_data[beat], exp_last[beat]);
          end
          case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 9) < 6);
            default: begin
              if (beat == stall_beat && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
              end else begin
                out_ready = 1'b1;
              end
            end
          endcase
          if (out_ready) begin
            seen[out_idx]   = 1'b1;
            shadow[out_idx] = out_data;
            beat++;
            holding = 0;
          end else begin
            stalls++;
            holding = 1;
            h_idx = out_idx; h_data = out_data; h_last = out_last;
          end
        end else begin
          if (holding) begin
            checks++;
            errors++;
            $display("FAIL %s valid_dropped: got valid=0 without handshake at t=%0d want 1", name, t);
            holding = 0;
          end
          if (ready_mode == 1) out_ready = $urandom_range(0, 1) == 1;
        end
        if (poke && t == 3) begin
          start = 1'b1;
          first = AW'($urandom);
          last  = AW'($urandom);
        end
      end
      if (!got_done) begin
        tick();
        t++;
      end
    end
    start = 1'b0;

    if (!got_done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done within %0d cycles want done", name, t);
    end
    checks++;
    if (beat != exp_idx.size()) begin
      errors++;
      $display("FAIL %s beat_count: got %0d want %0d", name, beat, exp_idx.size());
    end

    // Cycle after done: back in IDLE, ready for a new start
    out_ready = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || reg_sel !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s post_done: done=%b busy=%b sel=%0d valid=%b want all 0", name, done, busy, reg_sel, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; first = '0; last = '0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = $urandom; shadow[i] = '0; seen[i] = 1'b0;
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        reg_sel !== '0 || out_idx !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b valid=%b last=%b sel=%0d idx=%0d data=%h want all 0",
               busy, done, out_valid, out_last, reg_sel, out_idx, out_data);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
    apply_reset();
    do_scan(5'd1, 5'd3, 0, 0, 1'b0, "basic");
  endtask

  task automatic test_backpressure();
    apply_reset();
    do_scan(5'd1, 5'd3, 2, 1, 1'b0, "backpressure");
  endtask

  task automatic test_wrap();
    apply_reset();
    do_scan(5'd30, 5'd1, 0, 0, 1'b0, "wrap");
    do_scan(5'd7, 5'd7, 0, 0, 1'b0, "single");
    do_scan(5'd0, 5'd31, 1, 0, 1'b0, "full_range");
  endtask

  task automatic test_start_while_busy();
    apply_reset();
    do_scan(5'd4, 5'd9, 0, 0, 1'b1, "start_busy");
  endtask

  task automatic test_reset_mid_scan();
    rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
    apply_reset();
    start = 1'b1; first = 5'd1; last = 5'd3; out_ready = 1'b1;
    tick();                       // FETCH beat 1
    start = 1'b0;
    tick();                       // SEND beat 1, handshake at next edge
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd1 || out_data !== 32'h11) begin
      errors++;
      $display("FAIL rst_mid beat1: got (%b,%0d,%h) want (1,1,11)", out_valid, out_idx, out_data);
    end
    tick();                       // FETCH beat 2
    out_ready = 1'b0;
    tick();                       // SEND beat 2, stalled
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 5'd2 || out_data !== 32'h22) begin
      errors++;
      $display("FAIL rst_mid beat2: got (%b,%0d,%h) want (1,2,22)", out_valid, out_idx, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        reg_sel !== '0 || out_idx !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL rst_mid async_clear: busy=%b done=%b valid=%b last=%b sel=%0d idx=%0d data=%h want all 0",
               busy, done, out_valid, out_last, reg_sel, out_idx, out_data);
    end
    for (int i = 0; i < 32; i++) seen[i] = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid no_done: done=%b valid=%b at cycle %0d want 0/0", done, out_valid, c);
      end
      tick();
    end
    do_scan(5'd1, 5'd3, 0, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int s = 0; s < 8; s++) begin
      logic [AW-1:0] f, l;
      f = AW'($urandom);
      l = AW'($urandom_range(0, 1) == 1 ? int'(f) + $urandom_range(0, 6) : $urandom);
      if ($urandom_range(0, 1) == 1) rf[$urandom_range(0, 31)] = $urandom;
      do_scan(f, l, 1, 0, ($urandom_range(0, 3) == 0), "random");
    end
  endtask

`ifdef RF_DUMP_DELTA_EN
  task automatic test_delta();
    rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
    apply_reset();
    do_scan(5'd1, 5'd3, 0, 0, 1'b0, "delta_first");
    rf[2] = 32'h99;
    do_scan(5'd1, 5'd3, 0, 0, 1'b0, "delta_changed");
    do_scan(5'd1, 5'd3, 0, 0, 1'b0, "delta_none");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_start_while_busy();
    test_reset_mid_scan();
`ifdef RF_DUMP_DELTA_EN
    test_delta();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
